apple2_text_scanner: RTL

Apple II 40x24 text-mode scanner between `display_timings` and `hdmi`. It converts raster position into Apple II interleaved text-page addresses and fetches character codes from video RAM port B. It looks up glyph rows in the font ROM and applies normal, inverse and flash attributes. It emits 24-bit RGB with de/hs/vs delayed to match the fetch pipeline, and replaces the ad-hoc video address/pixel logic in the top level.

---
 rtl/apple2_text_scanner.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/apple2_text_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apple2_text_scanner: 40x24 Apple II text-mode fetch/glyph/colour pipeline |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module apple2_text_scanner #(
   parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
   parameter logic [23:0] BG_RGB     = 24'h30B030,
   parameter logic [23:0] BORDER_RGB = 24'h000000,
   parameter int          V_TOP      = 48,
   parameter int          FLASH_BIT  = 4
) (
   input  logic        i_pix_clk,
   input  logic        i_rst,
   input  logic [15:0] i_sx,
   input  logic [15:0] i_sy,
   input  logic        i_de,
   input  logic        i_hs,
   input  logic        i_vs,
   input  logic        i_page2,
   output logic [15:0] o_vram_addr,
   output logic        o_vram_en,
   input  logic [7:0]  i_vram_data,
   output logic [10:0] o_font_addr,
   input  logic [7:0]  i_font_data,
   output logic [7:0]  o_r,
   output logic [7:0]  o_g,
   output logic [7:0]  o_b,
   output logic        o_de,
   output logic        o_hs,
   output logic        o_vs
);

   localparam logic [15:0] TOP = 16'(V_TOP);
   localparam logic [15:0] BOT = 16'(V_TOP + 384);

   logic        in_area;
   logic [8:0]  ty;
   logic [4:0]  row;
   logic [5:0]  col;
   logic [15:0] base;
   logic [15:0] addr_next;
   logic        inv_next;
   logic        lit;

   logic [15:0] vram_addr_q;
   logic        vram_en_q;
   logic [3:0]  line1, line2;
   logic [2:0]  dot1, dot2, dot3, dot4;
   logic        in2, in3, in4;
   logic [10:0] font_addr_q;
   logic        inv3, inv4;
   logic [23:0] rgb_q;
   logic [4:0]  de_sr, hs_sr, vs_sr;
   logic [7:0]  frame_cnt;
   logic        page_q;
   logic        vs_prev;

   // Interleaved text page: 128 bytes per row-within-group, 40 bytes per group.
   always_comb begin
      in_area   = !i_sx[15] && (i_sx < 16'd640) &&
                  !i_sy[15] && (i_sy >= TOP) && (i_sy < BOT);
      ty        = 9'(i_sy - TOP);
      row       = ty[8:4];
      col       = i_sx[9:4];
      base      = page_q ? 16'h0800 : 16'h0400;
      addr_next = base
                + {6'd0, row[2:0], 7'd0}
                + {9'd0, row[4:3], 5'd0}
                + {11'd0, row[4:3], 3'd0}
                + {10'd0, col};
      inv_next  = (i_vram_data[7:6] == 2'b00) ||
                  ((i_vram_data[7:6] == 2'b01) && frame_cnt[FLASH_BIT]);
      lit       = i_font_data[3'd7 - dot4] ^ inv4;
   end

   always_ff @(posedge i_pix_clk) begin
      if (i_rst) begin
         vram_addr_q <= 16'h0400;
         vram_en_q   <= 1'b0;
         line1       <= '0;
         line2       <= '0;
         dot1        <= '0;
         dot2        <= '0;
         dot3        <= '0;
         dot4        <= '0;
         in2         <= 1'b0;
         in3         <= 1'b0;
         in4         <= 1'b0;
         font_addr_q <= '0;
         inv3        <= 1'b0;
         inv4        <= 1'b0;
         rgb_q       <= '0;
         de_sr       <= '0;
         hs_sr       <= '0;
         vs_sr       <= '0;
         frame_cnt   <= '0;
         page_q      <= 1'b0;
         vs_prev     <= 1'b0;
      end else begin
         vs_prev <= i_vs;
         if (i_vs && !vs_prev) begin
            frame_cnt <= frame_cnt + 8'd1;
            page_q    <= i_page2;
         end

         vram_addr_q <= addr_next;
         vram_en_q   <= in_area;
         line1       <= ty[3:0];
         dot1        <= i_sx[3:1];

         in2   <= vram_en_q;
         line2 <= line1;
         dot2  <= dot1;

         font_addr_q <= {~i_vram_data[5], i_vram_data[5:0], line2};
         inv3        <= inv_next;
         in3         <= in2;
         dot3        <= dot2;

         in4  <= in3;
         inv4 <= inv3;
         dot4 <= dot3;

         if (!de_sr[3])
            rgb_q <= 24'h000000;
         else if (!in4)
            rgb_q <= BORDER_RGB;
         else
            rgb_q <= lit ? FG_RGB : BG_RGB;

         de_sr <= {de_sr[3:0], i_de};
         hs_sr <= {hs_sr[3:0], i_hs};
         vs_sr <= {vs_sr[3:0], i_vs};
      end
   end

   assign o_vram_addr = vram_addr_q;
   assign o_vram_en   = vram_en_q;
   assign o_font_addr = font_addr_q;
   assign o_r         = rgb_q[23:16];
   assign o_g         = rgb_q[15:8];
   assign o_b         = rgb_q[7:0];
   assign o_de        = de_sr[4];
   assign o_hs        = hs_sr[4];
   assign o_vs        = vs_sr[4];

endmodule
`default_nettype wire
